// File: rtl/tdc_result_reader.sv
// tdc_result_reader
// Reads NUM_RESULTS TDC result registers over the parallel bus (CSN/RDN/addr/data)
// each time the TDC raises its interrupt. Each result goes downstream through a
// valid/ready handshake. A measurement reset is requested after the last result.
// Optional build macro: TDC_READ_TIMEOUT_EN enables an ARM-state watchdog that
// pulses timeout and meas_rst every TIMEOUT_CYCLES cycles without an interrupt.
module tdc_result_reader #(
    parameter int         NUM_RESULTS    = 4,
    parameter logic [3:0] RES_BASE       = 4'd0,
    parameter int         RD_CYCLES      = 3,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        intn,
    input  logic [27:0] data_in,
    output logic        CSN,
    output logic        RDN,
    output logic [3:0]  addr,
    output logic [27:0] result,
    output logic [2:0]  result_idx,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        meas_rst,
    output logic        timeout
);

    localparam int             RCW      = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
    localparam logic [RCW-1:0] RD_LAST  = RCW'(RD_CYCLES - 1);
    localparam logic [2:0]     IDX_LAST = 3'(NUM_RESULTS - 1);

    // Elaboration stops here when a parameter is outside its supported range.
    if (NUM_RESULTS < 1 || NUM_RESULTS > 8 || RD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_paramCheck
        $error("tdc_result_reader: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SETUP,
        S_READ,
        S_RECOV,
        S_OUT,
        S_DONE,
        S_WAITHI
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_intnS;
    logic [2:0]      r_idx;
    logic [RCW-1:0]  r_rdCnt;
    logic            r_csn;
    logic            r_rdn;
    logic [3:0]      r_addr;
    logic [27:0]     r_result;
    logic [2:0]      r_resultIdx;
    logic            r_valid;
    logic            r_measRst;

`ifdef TDC_READ_TIMEOUT_EN
    localparam int             TCW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
    logic [TCW-1:0]  r_tmoCnt;
    logic            r_timeout;
`endif

    // Two-flop synchronizer for the asynchronous interrupt; idles high like intn.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= intn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_intnS = r_sync2;

    // Read sequencer with registered bus and handshake outputs. Values assigned in a
    // state show up one cycle later, so CSN set high in RECOV rises a cycle after RDN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_rdCnt     <= '0;
            r_csn       <= 1'b1;
            r_rdn       <= 1'b1;
            r_addr      <= 4'd0;
            r_result    <= 28'd0;
            r_resultIdx <= 3'd0;
            r_valid     <= 1'b0;
            r_measRst   <= 1'b0;
`ifdef TDC_READ_TIMEOUT_EN
            r_tmoCnt    <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_measRst <= 1'b0;
`ifdef TDC_READ_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (!init_done) begin
                r_state <= S_IDLE;
                r_csn   <= 1'b1;
                r_rdn   <= 1'b1;
                r_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARM;
`ifdef TDC_READ_TIMEOUT_EN
                        r_tmoCnt <= '0;
`endif
                    end
                    S_ARM: begin
                        if (!w_intnS) begin
                            r_idx   <= 3'd0;
                            r_csn   <= 1'b0;
                            r_rdn   <= 1'b1;
                            r_addr  <= RES_BASE;
                            r_state <= S_SETUP;
                        end
`ifdef TDC_READ_TIMEOUT_EN
                        else if (r_tmoCnt == TMO_LAST) begin
                            r_timeout <= 1'b1;
                            r_measRst <= 1'b1;
                            r_tmoCnt  <= '0;
                        end else begin
                            r_tmoCnt <= r_tmoCnt + 1'b1;
                        end
`endif
                    end
                    S_SETUP: begin
                        r_rdn   <= 1'b0;
                        r_rdCnt <= '0;
                        r_state <= S_READ;
                    end
                    S_READ: begin
                        if (r_rdCnt == RD_LAST) begin
                            r_result    <= data_in;
                            r_resultIdx <= r_idx;
                            r_rdn       <= 1'b1;
                            r_state     <= S_RECOV;
                        end else begin
                            r_rdCnt <= r_rdCnt + 1'b1;
                        end
                    end
                    S_RECOV: begin
                        r_csn   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end
                    S_OUT: begin
                        if (result_ready) begin
                            r_valid <= 1'b0;
                            if (r_idx < IDX_LAST) begin
                                r_idx   <= r_idx + 3'd1;
                                r_csn   <= 1'b0;
                                r_addr  <= RES_BASE + {1'b0, r_idx + 3'd1};
                                r_state <= S_SETUP;
                            end else begin
                                r_measRst <= 1'b1;
                                r_state   <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_WAITHI;
                    end
                    S_WAITHI: begin
                        if (w_intnS) begin
                            r_state <= S_ARM;
`ifdef TDC_READ_TIMEOUT_EN
                            r_tmoCnt <= '0;
`endif
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign CSN          = r_csn;
    assign RDN          = r_rdn;
    assign addr         = r_addr;
    assign result       = r_result;
    assign result_idx   = r_resultIdx;
    assign result_valid = r_valid;
    assign meas_rst     = r_measRst;
`ifdef TDC_READ_TIMEOUT_EN
    assign timeout      = r_timeout;
`else
    assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_result_reader.sv
// tb_tdc_result_reader
// Directed bench for tdc_result_reader: reset state, 4-result bursts, downstream
// stall, no re-read of one interrupt, init_done abort and the ARM timeout
// (TDC_READ_TIMEOUT_EN builds) or its absence (default build).
`timescale 1ns/1ps
module tb_tdc_result_reader;

    localparam int RD  = 3;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        initDone;
    logic        intn;
    logic [27:0] dataIn;
    logic        csn;
    logic        rdn;
    logic [3:0]  addr;
    logic [27:0] result;
    logic [2:0]  resultIdx;
    logic        resultValid;
    logic        resultReady;
    logic        measRst;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int rdnRun = 0;
    int rdnBadLen = 0;
    int rdnNoCs = 0;
    int csnEarly = 0;
    int csnFalls = 0;
    int csnLowCycles = 0;
    int validCycles = 0;
    int measCount = 0;
    int timeoutCount = 0;
    int tmoNoMeas = 0;
    int unstable = 0;
    int busWhileValid = 0;
    int setupCyc = 0;
    int firstCsnCyc = -1;
    bit monEn = 1'b1;
    logic prevCsn = 1'b1;
    logic prevRdn = 1'b1;
    logic prevValid = 1'b0;
    logic [27:0] prevResult = '0;
    logic [2:0]  prevIdx = '0;

    logic [27:0] xferData[$];
    int          xferIdx[$];
    int          addrQ[$];
    int          latQ[$];
    int          tmoCycQ[$];

    // Register 0x0..0xF of the TDC returns 0x100 plus its address.
    assign dataIn = 28'h0000100 + {24'd0, addr};

    tdc_result_reader #(
        .NUM_RESULTS(4),
        .RES_BASE(4'd0),
        .RD_CYCLES(RD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .init_done(initDone),
        .intn(intn),
        .data_in(dataIn),
        .CSN(csn),
        .RDN(rdn),
        .addr(addr),
        .result(result),
        .result_idx(resultIdx),
        .result_valid(resultValid),
        .result_ready(resultReady),
        .meas_rst(measRst),
        .timeout(timeout)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Cycle counter, one per rising edge.
    always @(posedge clk) cyc++;

    // Bus and handshake monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rdn && csn) rdnNoCs++;
        if (!rdn) begin
            rdnRun++;
        end else begin
            if (rdnRun != 0 && monEn && rdnRun != RD) rdnBadLen++;
            rdnRun = 0;
        end
        if (monEn && csn && !prevCsn && !prevRdn) csnEarly++;
        if (!csn && prevCsn) begin
            csnFalls++;
            addrQ.push_back(int'(addr));
            setupCyc = cyc;
            if (firstCsnCyc < 0) firstCsnCyc = cyc;
        end
        if (!csn) csnLowCycles++;
        if (resultValid) validCycles++;
        if (resultValid && !prevValid) latQ.push_back(cyc - setupCyc);
        if (resultValid && prevValid && (result != prevResult || resultIdx != prevIdx)) unstable++;
        if (resultValid && !csn) busWhileValid++;
        if (resultValid && resultReady) begin
            xferData.push_back(result);
            xferIdx.push_back(int'(resultIdx));
        end
        if (measRst) measCount++;
        if (timeout) begin
            timeoutCount++;
            if (!measRst) tmoNoMeas++;
            tmoCycQ.push_back(cyc);
        end
        prevCsn    = csn;
        prevRdn    = rdn;
        prevValid  = resultValid;
        prevResult = result;
        prevIdx    = resultIdx;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives the inputs and lets the given number of cycles pass (ends 1 ns after an edge).
    task automatic applyStimulus(input logic initV, input logic intnV, input logic readyV, input int cycles);
        initDone    = initV;
        intn        = intnV;
        resultReady = readyV;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearQueues();
        xferData.delete();
        xferIdx.delete();
        addrQ.delete();
        latQ.delete();
    endtask

    // Bounded wait until the meas_rst pulse count reaches the target.
    task automatic waitMeas(input int target, input string tag);
        for (int n = 0; n < 400; n++) begin
            if (measCount >= target) break;
            @(posedge clk);
            #1;
        end
        checkOutput(tag, measCount, target);
    endtask

    // One full burst: results 0x100..0x103, indices 0..3, addresses 0..3, SETUP-to-valid = RD+2.
    task automatic checkBurst(input string tag);
        int badLat;
        checkOutput({tag, "_xfers"}, xferData.size(), 4);
        checkOutput({tag, "_setups"}, addrQ.size(), 4);
        for (int i = 0; i < 4 && i < xferData.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), {4'd0, xferData[i]}, 32'h100 + i);
            checkOutput($sformatf("%s_idx%0d", tag, i), xferIdx[i], i);
        end
        for (int i = 0; i < 4 && i < addrQ.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), addrQ[i], i);
        end
        badLat = 0;
        foreach (latQ[i]) if (latQ[i] != RD + 2) badLat++;
        checkOutput({tag, "_latency"}, badLat, 0);
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        int base;
        bit got;

        reset = 1'b1;
        initDone = 1'b0;
        intn = 1'b1;
        resultReady = 1'b1;
        @(posedge clk);
        #1;

        // Reset values.
        applyStimulus(1'b0, 1'b1, 1'b1, 10);
        checkOutput("rst_csn", 32'(csn), 1);
        checkOutput("rst_rdn", 32'(rdn), 1);
        checkOutput("rst_addr", 32'(addr), 0);
        checkOutput("rst_result", 32'(result), 0);
        checkOutput("rst_idx", 32'(resultIdx), 0);
        checkOutput("rst_valid", 32'(resultValid), 0);
        checkOutput("rst_measrst", 32'(measRst), 0);
        checkOutput("rst_timeout", 32'(timeout), 0);

        // Armed with no interrupt: bus idle, nothing valid.
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 20);
        checkOutput("idle_csnLow", csnLowCycles, 0);
        checkOutput("idle_valid", validCycles, 0);
        checkOutput("idle_meas", measCount, 0);

        // Burst 1: ready always high.
        clearQueues();
        firstCsnCyc = -1;
        intn = 1'b0;
        k = cyc;
        waitMeas(1, "b1_meas");
        applyStimulus(1'b1, 1'b0, 1'b1, 10);
        checkOutput("b1_singleMeas", measCount, 1);
        checkOutput("b1_intnLatency", 32'(firstCsnCyc - k >= 3 && firstCsnCyc - k <= 4), 1);
        checkBurst("b1");

        // Burst 2: ready pulsed per result, idx 1 stalled 20 cycles.
        applyStimulus(1'b1, 1'b1, 1'b0, 5);
        clearQueues();
        base = busWhileValid;
        k = unstable;
        intn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            for (int n = 0; n < 100; n++) begin
                if (resultValid) begin
                    got = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            checkOutput($sformatf("b2_wait%0d", i), 32'(got), 1);
            if (i == 1) begin
                repeat (20) begin
                    @(posedge clk);
                    #1;
                end
                checkOutput("stall_valid", 32'(resultValid), 1);
                checkOutput("stall_result", {4'd0, result}, 32'h101);
                checkOutput("stall_idx", 32'(resultIdx), 1);
                checkOutput("stall_csn", 32'(csn), 1);
                checkOutput("stall_setups", addrQ.size(), 2);
            end
            resultReady = 1'b1;
            @(posedge clk);
            #1;
            resultReady = 1'b0;
        end
        waitMeas(2, "b2_meas");
        checkBurst("b2");
        checkOutput("b2_unstable", unstable - k, 0);
        checkOutput("b2_busWhileValid", busWhileValid - base, 0);

        // intn held low after DONE: no second read of the same interrupt.
        base = csnFalls;
        applyStimulus(1'b1, 1'b0, 1'b1, 50);
        checkOutput("hold_noRead", csnFalls, base);
        checkOutput("hold_noMeas", measCount, 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 5);
        clearQueues();
        intn = 1'b0;
        waitMeas(3, "b3_meas");
        checkBurst("b3");

        // init_done dropped during the read of idx 2.
        applyStimulus(1'b1, 1'b1, 1'b1, 5);
        monEn = 1'b0;
        intn = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (!rdn && addr == 4'd2) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("abort_reachRead2", 32'(got), 1);
        initDone = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_csn", 32'(csn), 1);
        checkOutput("abort_rdn", 32'(rdn), 1);
        checkOutput("abort_valid", 32'(resultValid), 0);
        base = csnFalls;
        applyStimulus(1'b0, 1'b1, 1'b1, 10);
        checkOutput("abort_noMeas", measCount, 3);
        checkOutput("abort_busIdle", csnFalls, base);
        monEn = 1'b1;
        clearQueues();
        applyStimulus(1'b1, 1'b0, 1'b1, 0);
        waitMeas(4, "b4_meas");
        checkBurst("b4");

        // ARM with no interrupt for a long time.
        applyStimulus(1'b1, 1'b1, 1'b1, 5);
        base = timeoutCount;
        k = measCount;
        tmoCycQ.delete();
`ifdef TDC_READ_TIMEOUT_EN
        applyStimulus(1'b1, 1'b1, 1'b1, 350);
        checkOutput("tmo_pulses", 32'(timeoutCount - base >= 3), 1);
        checkOutput("tmo_withMeas", tmoNoMeas, 0);
        checkOutput("tmo_measCount", measCount - k, timeoutCount - base);
        for (int i = 0; i + 1 < tmoCycQ.size() && i < 2; i++) begin
            checkOutput($sformatf("tmo_period%0d", i), tmoCycQ[i + 1] - tmoCycQ[i], TMO);
        end
`else
        applyStimulus(1'b1, 1'b1, 1'b1, 300);
        checkOutput("noTmo_pulses", timeoutCount - base, 0);
        checkOutput("noTmo_meas", measCount - k, 0);
        checkOutput("noTmo_level", 32'(timeout), 0);
`endif

        // Bus protocol invariants over the whole run.
        checkOutput("inv_rdnWithoutCs", rdnNoCs, 0);
        checkOutput("inv_rdnLength", rdnBadLen, 0);
        checkOutput("inv_csnEarlyRise", csnEarly, 0);

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
